dram_cmd_sched: RTL

//  Next-generation DRAM command sequencer: accepts one read/write burst request at a time.

---
 rtl/dram_cmd_sched.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/dram_cmd_sched.sv
// dram_cmd_sched: single-request DRAM command sequencer with a per-bank open-row table.
// One burst request is in flight at a time. The sequencer emits ACT/RD/WR/PRE/PREA/REF
// on a req/ack command channel and serves pending refreshes only from IDLE.
// Optional build macro DRAM_AUTO_PRECHARGE_EN selects a closed-page policy: every burst
// is followed by PRE of its bank. Without the macro, rows stay open (open-page policy).
module dram_cmd_sched #(
  parameter int NUMBER_OF_BANKS = 8,
  parameter int NUMBER_OF_ROWS  = 128,
  parameter int NUMBER_OF_COLS  = 8,
  parameter int BURST_LEN       = 4,
  parameter int MAX_REF_PEND    = 8
) (
  input  logic                                    clk,
  input  logic                                    rst_b,
  input  logic                                    addr_val,
  output logic                                    addr_rdy,
  input  logic                                    req_rw,
  input  logic [$clog2(NUMBER_OF_BANKS)-1:0]      bank_id,
  input  logic [$clog2(NUMBER_OF_ROWS)-1:0]       row_id,
  input  logic [$clog2(NUMBER_OF_COLS)-1:0]       col_id,
  input  logic                                    refresh_flag,
  output logic                                    cmd_req,
  input  logic                                    cmd_ack,
  output logic [2:0]                              cmd,
  output logic [$clog2(NUMBER_OF_BANKS)-1:0]      cmd_bank,
  output logic [$clog2(NUMBER_OF_ROWS)-1:0]       cmd_row,
  output logic [$clog2(NUMBER_OF_COLS)-1:0]       cmd_col,
  output logic                                    busy,
  output logic [$clog2(MAX_REF_PEND+1)-1:0]       ref_pend
);

  localparam int BW       = $clog2(NUMBER_OF_BANKS);
  localparam int RW       = $clog2(NUMBER_OF_ROWS);
  localparam int CW       = $clog2(NUMBER_OF_COLS);
  localparam int PW       = $clog2(MAX_REF_PEND+1);
  localparam int LAST_INT = BURST_LEN - 1;

  // Column arithmetic is one bit wider so start column + beat never overflows before the wrap.
  localparam logic [CW:0]   COLS_W    = NUMBER_OF_COLS[CW:0];
  localparam logic [CW:0]   LAST_BEAT = LAST_INT[CW:0];
  localparam logic [PW-1:0] REF_MAX   = MAX_REF_PEND[PW-1:0];

  localparam logic [2:0] CMD_ACT  = 3'b000;
  localparam logic [2:0] CMD_RD   = 3'b001;
  localparam logic [2:0] CMD_WR   = 3'b010;
  localparam logic [2:0] CMD_PRE  = 3'b011;
  localparam logic [2:0] CMD_PREA = 3'b100;
  localparam logic [2:0] CMD_REF  = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE, S_ACT, S_COL, S_PRE, S_PREA, S_REF, S_PRE_AP
  } state_t;

  state_t          state_q, state_d;
  logic            rw_q, rw_d;
  logic [BW-1:0]   bank_q, bank_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [CW:0]     beat_q, beat_d;
  logic [PW-1:0]   ref_pend_q, ref_pend_d;
  logic            cmd_req_q, cmd_req_d;
  logic [2:0]      cmd_q, cmd_d;
  logic [BW-1:0]   cmd_bank_q, cmd_bank_d;
  logic [RW-1:0]   cmd_row_q, cmd_row_d;
  logic [CW-1:0]   cmd_col_q, cmd_col_d;
  logic            open_valid_q [NUMBER_OF_BANKS];
  logic            open_valid_d [NUMBER_OF_BANKS];
  logic [RW-1:0]   open_row_q   [NUMBER_OF_BANKS];
  logic [RW-1:0]   open_row_d   [NUMBER_OF_BANKS];

  logic            ack;
  logic            accept;
  logic            any_open;
  logic [CW:0]     col_sum;
  logic [PW-1:0]   ref_cnt;

  // An ack only counts while a command is actually being presented.
  assign ack      = cmd_req_q & cmd_ack;
  assign addr_rdy = (state_q == S_IDLE) && (ref_pend_q == '0) && rst_b;
  assign accept   = addr_val & addr_rdy;
  assign busy     = (state_q != S_IDLE);
  assign ref_pend = ref_pend_q;
  assign cmd_req  = cmd_req_q;
  assign cmd      = cmd_q;
  assign cmd_bank = cmd_bank_q;
  assign cmd_row  = cmd_row_q;
  assign cmd_col  = cmd_col_q;

  // Next state, open-row table update, refresh counter, and the command to present next cycle.
  always_comb begin
    state_d      = state_q;
    rw_d         = rw_q;
    bank_d       = bank_q;
    row_d        = row_q;
    col_d        = col_q;
    beat_d       = beat_q;
    open_valid_d = open_valid_q;
    open_row_d   = open_row_q;
    cmd_req_d    = 1'b0;
    cmd_d        = CMD_ACT;
    cmd_bank_d   = '0;
    cmd_row_d    = '0;
    cmd_col_d    = '0;

    any_open = 1'b0;
    for (int i = 0; i < NUMBER_OF_BANKS; i++) begin
      any_open = any_open | open_valid_q[i];
    end

    // A REF completion and a new refresh pulse on the same edge cancel out.
    ref_cnt = ref_pend_q;
    if (state_q == S_REF && ack) ref_cnt = ref_cnt - 1'b1;
    if (refresh_flag && ref_cnt != REF_MAX) ref_cnt = ref_cnt + 1'b1;
    ref_pend_d = ref_cnt;

    case (state_q)
      S_IDLE: begin
        if (ref_pend_q != '0) begin
          state_d = any_open ? S_PREA : S_REF;
        end else if (accept) begin
          rw_d   = req_rw;
          bank_d = bank_id;
          row_d  = row_id;
          col_d  = col_id;
          beat_d = '0;
          if (open_valid_q[bank_id] && open_row_q[bank_id] == row_id) state_d = S_COL;
          else if (open_valid_q[bank_id])                             state_d = S_PRE;
          else                                                        state_d = S_ACT;
        end
      end
      S_ACT: if (ack) begin
        open_valid_d[bank_q] = 1'b1;
        open_row_d[bank_q]   = row_q;
        beat_d               = '0;
        state_d              = S_COL;
      end
      S_PRE: if (ack) begin
        open_valid_d[bank_q] = 1'b0;
        state_d              = S_ACT;
      end
      S_COL: if (ack) begin
        if (beat_q == LAST_BEAT) begin
          beat_d = '0;
`ifdef DRAM_AUTO_PRECHARGE_EN
          state_d = S_PRE_AP;
`else
          state_d = S_IDLE;
`endif
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
`ifdef DRAM_AUTO_PRECHARGE_EN
      S_PRE_AP: if (ack) begin
        open_valid_d[bank_q] = 1'b0;
        state_d              = S_IDLE;
      end
`endif
      S_PREA: if (ack) begin
        for (int i = 0; i < NUMBER_OF_BANKS; i++) open_valid_d[i] = 1'b0;
        state_d = S_REF;
      end
      S_REF: if (ack && ref_pend_d == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Burst columns wrap inside the row.
    col_sum = {1'b0, col_d} + beat_d;
    if (col_sum >= COLS_W) col_sum = col_sum - COLS_W;

    case (state_d)
      S_ACT: begin
        cmd_req_d = 1'b1; cmd_d = CMD_ACT; cmd_bank_d = bank_d; cmd_row_d = row_d;
      end
      S_COL: begin
        cmd_req_d  = 1'b1;
        cmd_d      = rw_d ? CMD_WR : CMD_RD;
        cmd_bank_d = bank_d;
        cmd_col_d  = col_sum[CW-1:0];
      end
      S_PRE, S_PRE_AP: begin
        cmd_req_d = 1'b1; cmd_d = CMD_PRE; cmd_bank_d = bank_d;
      end
      S_PREA: begin cmd_req_d = 1'b1; cmd_d = CMD_PREA; end
      S_REF:  begin cmd_req_d = 1'b1; cmd_d = CMD_REF;  end
      default: cmd_req_d = 1'b0;
    endcase
  end

  // Sequencer state, latched request and registered command outputs.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q    <= S_IDLE;
      rw_q       <= 1'b0;
      bank_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      beat_q     <= '0;
      ref_pend_q <= '0;
      cmd_req_q  <= 1'b0;
      cmd_q      <= CMD_ACT;
      cmd_bank_q <= '0;
      cmd_row_q  <= '0;
      cmd_col_q  <= '0;
    end else begin
      state_q    <= state_d;
      rw_q       <= rw_d;
      bank_q     <= bank_d;
      row_q      <= row_d;
      col_q      <= col_d;
      beat_q     <= beat_d;
      ref_pend_q <= ref_pend_d;
      cmd_req_q  <= cmd_req_d;
      cmd_q      <= cmd_d;
      cmd_bank_q <= cmd_bank_d;
      cmd_row_q  <= cmd_row_d;
      cmd_col_q  <= cmd_col_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUMBER_OF_BANKS; gi++) begin : g_bank
      // Per-bank open-row entry; reset closes every bank.
      always_ff @(posedge clk) begin
        if (!rst_b) begin
          open_valid_q[gi] <= 1'b0;
          open_row_q[gi]   <= '0;
        end else begin
          open_valid_q[gi] <= open_valid_d[gi];
          open_row_q[gi]   <= open_row_d[gi];
        end
      end
    end
  endgenerate

endmodule
